// File: rtl/hazard_scoreboard_if.sv
// ID/WB-side signal bundle for the hazard scoreboard.
// The master drives decode and writeback info; the slave (scoreboard) returns stall and status.
interface hazard_scoreboard_if #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned REG_W    = 4
);
    logic                issue_valid;
    logic                issue_wb_en;
    logic [REG_W-1:0]    issue_dest;
    logic                issue_is_load;
    logic [REG_W-1:0]    src1;
    logic [REG_W-1:0]    src2;
    logic                two_src;
    logic                flush;
    logic                forward_en;
    logic                wb_valid;
    logic [REG_W-1:0]    wb_dest;
    logic                hazard;
    logic [NUM_REGS-1:0] pending_mask;
    logic                err;

    modport master (
        output issue_valid, issue_wb_en, issue_dest, issue_is_load,
        output src1, src2, two_src, flush, forward_en, wb_valid, wb_dest,
        input  hazard, pending_mask, err
    );

    modport slave (
        input  issue_valid, issue_wb_en, issue_dest, issue_is_load,
        input  src1, src2, two_src, flush, forward_en, wb_valid, wb_dest,
        output hazard, pending_mask, err
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes between ID issue and WB retirement and
// raises a combinational ID stall when a source operand is not yet usable.
module hazard_scoreboard #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned REG_W    = 4,
    parameter int unsigned CNT_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0]    r_cnt [NUM_REGS];
    logic                r_exe_load_valid;
    logic [REG_W-1:0]    r_exe_load_dest;
    logic                r_err;

    logic [CNT_W-1:0]    w_cnt_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] w_inc_hit;
    logic [NUM_REGS-1:0] w_dec_hit;
    logic [NUM_REGS-1:0] w_pending;
    logic                w_err_set;
    logic                w_haz_nofwd;
    logic                w_haz_fwd;
    logic                w_hazard;
    logic                w_accept;
    logic                w_inc;

    // Without forwarding any pending write blocks; with it only a load still in EXE does.
    assign w_haz_nofwd = (r_cnt[bus.src1] != '0) |
                         (bus.two_src & (r_cnt[bus.src2] != '0));
    assign w_haz_fwd   = r_exe_load_valid &
                         ((bus.src1 == r_exe_load_dest) |
                          (bus.two_src & (bus.src2 == r_exe_load_dest)));
    assign w_hazard    = bus.issue_valid & (bus.forward_en ? w_haz_fwd : w_haz_nofwd);
    assign w_accept    = bus.issue_valid & ~w_hazard & ~bus.flush;
    assign w_inc       = w_accept & bus.issue_wb_en;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        assign w_inc_hit[g] = w_inc & (bus.issue_dest == REG_W'(g));
        assign w_dec_hit[g] = bus.wb_valid & (bus.wb_dest == REG_W'(g));
        assign w_pending[g] = (r_cnt[g] != '0);
    end

    // Saturating per-register counters; a matched inc/dec pair cancels out.
    always_comb begin
        w_err_set = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_inc_hit[i] && !w_dec_hit[i]) begin
                if (r_cnt[i] == CNT_MAX) w_err_set = 1'b1;
                else                     w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end else if (w_dec_hit[i] && !w_inc_hit[i]) begin
                if (r_cnt[i] == '0) w_err_set = 1'b1;
                else                w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
            r_exe_load_valid <= 1'b0;
            r_exe_load_dest  <= '0;
            r_err            <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) r_cnt[i] <= w_cnt_nxt[i];
            // Any bubble or flush drops the tag, so a load-use stall lasts one cycle.
            r_exe_load_valid <= w_inc & bus.issue_is_load;
            if (w_inc & bus.issue_is_load) r_exe_load_dest <= bus.issue_dest;
            if (w_err_set) r_err <= 1'b1;
        end
    end

    assign bus.hazard       = w_hazard;
    assign bus.pending_mask = w_pending;
    assign bus.err          = r_err;
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side companion to the forwarding mux control: tracks which architectural registers have in-flight writes between ID issue and WB retirement.
- Raises a stall to the ID stage when a source operand cannot be satisfied.
  - With forwarding disabled, any pending write to a source stalls.
  - With forwarding enabled, only a load-use dependency on the instruction currently in EXE stalls.
- Sits beside the ID/EXE pipeline register. It is fed by ID-stage decode and by the WB-stage write port.

Parameters:
- NUM_REGS, 16, number of architectural registers tracked (R0-R15).
- REG_W, 4, register index width.
- CNT_W, 2, width of per-register in-flight counter (max 2^CNT_W-1 = 3 outstanding writes per register).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- issue_valid  input  1  ID holds a valid instruction requesting issue to EXE.
- issue_wb_en  input  1  issuing instruction writes a register.
- issue_dest  input  REG_W  destination register of issuing instruction.
- issue_is_load  input  1  issuing instruction is a memory read (result available only after MEM).
- src1  input  REG_W  first source register of the ID instruction.
- src2  input  REG_W  second source register of the ID instruction.
- two_src  input  1  src2 is a real operand (else ignored).
- flush  input  1  branch-taken kill of the ID instruction this cycle.
- forward_en  input  1  forwarding path enabled (mode select).
- wb_valid  input  1  WB stage writes a register this cycle.
- wb_dest  input  REG_W  register written by WB.
- hazard  output  1  stall ID/freeze IF this cycle (combinational).
- pending_mask  output  NUM_REGS  bit i = 1 when counter i is non-zero (registered state).
- err  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset (async, rst=1): all counters = 0, exe_load_valid = 0, exe_load_dest = 0, err = 0. Hence hazard = 0 and pending_mask = 0 while rst is asserted. A reset mid-operation discards all in-flight tracking immediately.
- src1 is always checked. src2 is checked only when two_src = 1.
- hazard, combinational, gated by issue_valid:
  - forward_en = 0: hazard = 1 if the counter of any checked source is non-zero.
  - forward_en = 1: hazard = 1 if exe_load_valid = 1 and a checked source equals exe_load_dest.
  - issue_valid = 0: hazard = 0.
- Concurrent WB does not clear hazard in the same cycle. Counters read the current state, so the result is conservative: a one-cycle extra stall when WB and the consumer coincide.
- accept = issue_valid & ~hazard & ~flush.
- Counter update at posedge:
  - inc = accept & issue_wb_en on issue_dest; dec = wb_valid on wb_dest.
  - Same register with both inc and dec: counter unchanged.
  - Different registers: both updated.
- Saturation and error:
  - Increment at max (3): counter holds 3, err <= 1.
  - Decrement at 0: counter holds 0, err <= 1.
  - err clears only on rst.
- EXE load tag at posedge:
  - exe_load_valid <= accept & issue_wb_en & issue_is_load.
  - exe_load_dest <= issue_dest when that is 1.
  - Any non-accepted cycle (stall bubble or flush) clears exe_load_valid. A load-use stall is therefore exactly 1 cycle.
- Latency: issue visible in pending_mask and in the forward_en = 0 hazard the cycle after accept. WB decrement is visible the cycle after wb_valid.
- flush: no accept. Counters still honour wb_valid. flush does not clear older in-flight entries, because they still retire through WB.
- All 16 registers are tracked uniformly, including R15. Indices are compared at full REG_W width.

Test Plan:
- Reset: rst pulse asynchronously mid-cycle with counters non-zero -> pending_mask = 0, err = 0, hazard = 0 immediately.
- No-forward RAW: forward_en = 0; issue ADD R3 (accept); next cycle src1 = R3 -> hazard = 1. Hold until wb_valid with wb_dest = 3; hazard = 0 on the cycle after, and pending_mask[3] goes 1 -> 0.
- Load-use: forward_en = 1; accept LDR R5; next cycle src2 = R5 with two_src = 1 -> hazard = 1 for exactly 1 cycle, then 0 with a bubble. With two_src = 0 -> hazard = 0.
- Simultaneous inc/dec: counter[7] = 1; accept write R7 while wb_valid with wb_dest = 7 -> counter[7] stays 1 and pending_mask[7] = 1.
- Saturation/underflow: 4 accepted writes to R2 with no WB -> counter = 3, err = 1. After reset, wb_valid to R9 -> err = 1 and pending_mask[9] = 0.
- Flush: issue_valid = 1, flush = 1, issue_wb_en with dest R4 -> counter[4] unchanged and exe_load_valid = 0 next cycle.
